// File: rtl/cam_capture_pkg.sv
// cam_capture_pkg: capture FSM state type, luma weights and default frame geometry
// shared by cam_luma_capture and rgb565_to_luma.
package cam_capture_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SYNC = 2'd1,
    S_CAPT = 2'd2,
    S_DONE = 2'd3
  } cap_state_e;

  localparam logic [15:0] LUMA_CR = 16'd77;
  localparam logic [15:0] LUMA_CG = 16'd150;
  localparam logic [15:0] LUMA_CB = 16'd29;

  localparam int DEF_SRC_W = 320;
  localparam int DEF_SRC_H = 240;
  localparam int DEF_DECIM = 1;

endpackage

// File: rtl/rgb565_to_luma.sv
// rgb565_to_luma: two-stage RGB565 -> 8-bit luma converter.
// CAM_LUMA_WEIGHTED_EN selects weighted luma; otherwise luma is the expanded green channel.
module rgb565_to_luma
  import cam_capture_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] pix_i,
  output logic [7:0]  luma_o
);

  logic [7:0] g8;
  logic [7:0] luma_q;

  assign g8     = {pix_i[10:5], pix_i[10:9]};
  assign luma_o = luma_q;

`ifdef CAM_LUMA_WEIGHTED_EN
  logic [7:0]  r8, b8;
  logic [15:0] pr_q, pg_q, pb_q;
  logic [15:0] sum;
  logic        unused_sum;

  assign r8 = {pix_i[15:11], pix_i[15:13]};
  assign b8 = {pix_i[4:0], pix_i[4:2]};
  // Weights total 256, so the sum of three weighted 8-bit channels fits 16 bits.
  assign sum        = pr_q + pg_q + pb_q;
  assign unused_sum = ^sum[7:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pr_q   <= '0;
      pg_q   <= '0;
      pb_q   <= '0;
      luma_q <= '0;
    end else begin
      pr_q   <= LUMA_CR * {8'h00, r8};
      pg_q   <= LUMA_CG * {8'h00, g8};
      pb_q   <= LUMA_CB * {8'h00, b8};
      luma_q <= sum[15:8];
    end
  end
`else
  logic [7:0] g_q;
  logic       unused_rb;

  assign unused_rb = ^{pix_i[15:11], pix_i[4:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_q    <= '0;
      luma_q <= '0;
    end else begin
      g_q    <= g8;
      luma_q <= g_q;
    end
  end
`endif

endmodule

// File: rtl/cam_luma_capture.sv
// cam_luma_capture: captures RGB565 byte pairs from a VSYNC/HREF camera, decimates by 2**DECIM
// and writes 8-bit luma to a frame buffer. Define CAM_LUMA_WEIGHTED_EN for weighted luma.
module cam_luma_capture
  import cam_capture_pkg::*;
#(
  parameter int SRC_W = DEF_SRC_W,
  parameter int SRC_H = DEF_SRC_H,
  parameter int DECIM = DEF_DECIM
) (
  input  logic        PIXCLK,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        VSYNC,
  input  logic        HREF,
  input  logic [9:0]  PIXDATA,
  output logic        wr_en,
  output logic [14:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        frame_done,
  output logic        frame_err,
  output logic        busy
);

  localparam logic [15:0] SRC_W16  = 16'(SRC_W);
  localparam logic [15:0] SRC_H16  = 16'(SRC_H);
  localparam logic [15:0] DEC_MASK = 16'((1 << DECIM) - 1);
  localparam logic [31:0] DST_W32  = 32'(SRC_W >> DECIM);

  cap_state_e  state_q, state_d;
  logic        vsync_q, href_q, phase_q;
  logic [7:0]  hi_q;
  logic [15:0] col_q, line_q;
  logic [15:0] pix_q;
  logic [14:0] addr0_q, addr1_q, addr2_q;
  logic        vld0_q, vld1_q, vld2_q;
  logic [1:0]  done_q;
  logic        err_q;
  logic        vsync_rise, vsync_fall, href_rise, href_fall;
  logic        frame_start, capt, keep_d;
  logic [31:0] addr_full;
  logic        unused_bits;

  assign vsync_rise  = VSYNC & ~vsync_q;
  assign vsync_fall  = ~VSYNC & vsync_q;
  assign href_rise   = HREF & ~href_q;
  assign href_fall   = ~HREF & href_q;
  assign frame_start = (state_q == S_SYNC) && vsync_rise;
  assign capt        = (state_q == S_CAPT);

  // The byte that arrives with an HREF rise is always a high byte, so it never completes a pixel.
  assign keep_d = capt && HREF && !href_rise && phase_q &&
                  (col_q < SRC_W16) && (line_q < SRC_H16) &&
                  ((col_q & DEC_MASK) == '0) && ((line_q & DEC_MASK) == '0);

  assign addr_full   = {16'h0000, line_q >> DECIM} * DST_W32 + {16'h0000, col_q >> DECIM};
  assign unused_bits = ^{PIXDATA[1:0], addr_full[31:15]};

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (enable) state_d = S_SYNC;
      S_SYNC: begin
        if (!enable)         state_d = S_IDLE;
        else if (vsync_rise) state_d = S_CAPT;
      end
      S_CAPT: if (vsync_fall) state_d = S_DONE;
      S_DONE: state_d = enable ? S_SYNC : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge PIXCLK or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge PIXCLK or negedge reset_n) begin
    if (!reset_n) begin
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      phase_q <= 1'b0;
      hi_q    <= '0;
      col_q   <= '0;
      line_q  <= '0;
    end else begin
      vsync_q <= VSYNC;
      href_q  <= HREF;
      if (frame_start) begin
        col_q   <= '0;
        line_q  <= '0;
        phase_q <= 1'b0;
      end else if (capt) begin
        if (href_fall) begin
          line_q  <= line_q + 16'd1;
          col_q   <= '0;
          phase_q <= 1'b0;
        end else if (HREF) begin
          if (href_rise || !phase_q) begin
            hi_q    <= PIXDATA[9:2];
            phase_q <= 1'b1;
          end else begin
            col_q   <= col_q + 16'd1;
            phase_q <= 1'b0;
          end
        end
      end
    end
  end

  // frame_done rides the same two-cycle delay as the pixel path so a pixel completed on the
  // closing VSYNC edge is written in the frame_done cycle.
  always_ff @(posedge PIXCLK or negedge reset_n) begin
    if (!reset_n) begin
      pix_q   <= '0;
      addr0_q <= '0;
      addr1_q <= '0;
      addr2_q <= '0;
      vld0_q  <= 1'b0;
      vld1_q  <= 1'b0;
      vld2_q  <= 1'b0;
      done_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      vld0_q <= keep_d;
      vld1_q <= vld0_q;
      vld2_q <= vld1_q;
      if (keep_d) begin
        pix_q   <= {hi_q, PIXDATA[9:2]};
        addr0_q <= addr_full[14:0];
      end
      addr1_q <= addr0_q;
      addr2_q <= addr1_q;
      done_q  <= {done_q[0], state_q == S_DONE};
      if ((state_q == S_DONE) && (line_q != SRC_H16)) err_q <= 1'b1;
      else if (frame_start)                           err_q <= 1'b0;
    end
  end

  rgb565_to_luma u_luma (
    .clk   (PIXCLK),
    .rst_n (reset_n),
    .pix_i (pix_q),
    .luma_o(wr_data)
  );

  assign wr_en      = vld2_q;
  assign wr_addr    = addr2_q;
  assign frame_done = done_q[1];
  assign frame_err  = err_q;
  assign busy       = (state_q == S_SYNC) || (state_q == S_CAPT);

endmodule

// File: doc/cam_luma_capture.md
CAM_LUMA_CAPTURE -- requirements
Module: cam_luma_capture

Interface
REQ-001 The module SHALL have parameter SRC_W, default 320, camera active pixels per line.
REQ-002 The module SHALL have parameter SRC_H, default 240, camera active lines per frame.
REQ-003 The module SHALL have parameter DECIM, default 1, log2 decimation factor applied in both axes.
REQ-004 The module SHALL have port PIXCLK  in  1  sole clock; all logic on the rising edge.
REQ-005 The module SHALL have port reset_n  in  1  reset; one clock, reset asynchronous and active-low.
REQ-006 The module SHALL have port enable  in  1  capture request, level-sensitive.
REQ-007 The module SHALL have port VSYNC  in  1  high during the frame-valid window.
REQ-008 The module SHALL have port HREF  in  1  high during active line bytes.
REQ-009 The module SHALL have port PIXDATA  in  10  camera byte on bits [9:2]; bits [1:0] ignored.
REQ-010 The module SHALL have port wr_en  out  1  frame-buffer write strobe.
REQ-011 The module SHALL have port wr_addr  out  15  frame-buffer word address.
REQ-012 The module SHALL have port wr_data  out  8  luma value.
REQ-013 The module SHALL have port frame_done  out  1  one-cycle pulse at end of each captured frame.
REQ-014 The module SHALL have port frame_err  out  1  sticky; last frame's line count was not SRC_H; cleared at next frame start.
REQ-015 The module SHALL have port busy  out  1  high in S_SYNC and S_CAPT.

Function
REQ-016 The FSM SHALL have states S_IDLE, S_SYNC, S_CAPT and S_DONE.
REQ-017 S_IDLE SHALL go to S_SYNC when enable=1.
REQ-018 S_SYNC SHALL go to S_CAPT on a VSYNC rising edge (prev 0, now 1); a frame already in progress at entry SHALL be skipped.
REQ-019 S_CAPT SHALL go to S_DONE on a VSYNC falling edge.
REQ-020 S_DONE SHALL last one cycle with frame_done=1, then go to S_SYNC if enable=1, else S_IDLE.
REQ-021 Deasserting enable in S_CAPT SHALL NOT abort the frame; the frame completes normally.
REQ-022 Byte phase SHALL reset on every HREF rising edge; the first byte is the high byte {R5,G[5:3]}, the second the low byte {G[2:0],B5}.
REQ-023 Column SHALL increment per completed pixel; line SHALL increment on each HREF falling edge; both SHALL clear at frame start.
REQ-024 Pixels with col>=SRC_W or line>=SRC_H SHALL be dropped; an odd trailing byte at the HREF fall SHALL be discarded.
REQ-025 A pixel SHALL be kept only if col and line have their low DECIM bits zero.
REQ-026 Address SHALL be (line>>DECIM)*(SRC_W>>DECIM)+(col>>DECIM), computed to full width, then truncated to 15 bits.
REQ-027 Expansion to 8 bits SHALL be R8={R,R[4:2]}, G8={G,G[5:4]}, B8={B,B[4:2]}.
REQ-028 wr_en, wr_addr and wr_data SHALL be registered and valid exactly 2 cycles after the low byte's clock edge, identical in both configurations.
REQ-029 At S_DONE, frame_err SHALL be set if the line count != SRC_H.
REQ-030 If a VSYNC fall coincides with the last pixel's low byte, that pixel SHALL still be written, and frame_done SHALL follow in the same cycle as the pixel's write.

Reset
REQ-031 Under reset the FSM SHALL be in S_IDLE and wr_en, wr_addr, wr_data, frame_done, frame_err, busy and all counters and pipeline registers SHALL be 0.
REQ-032 Reset asserted mid-frame SHALL discard in-flight pixels, produce no write after release, and require a fresh VSYNC rise to capture.

Configuration
REQ-033 With CAM_LUMA_WEIGHTED_EN defined, luma SHALL be (77*R8+150*G8+29*B8)>>8 using 16-bit unsigned intermediates.
REQ-034 Without CAM_LUMA_WEIGHTED_EN, luma SHALL be G8, with no multipliers.

Structure
REQ-035 Package cam_capture_pkg SHALL hold the FSM state typedef, luma coefficients (77/150/29) and default SRC_W/SRC_H/DECIM constants.
REQ-036 Colour conversion SHALL be sub-module rgb565_to_luma: 2-stage pipeline, 16-bit pixel in, 8-bit luma out, macro-selected.

Verification
REQ-037 Bench scenario 1: enable=1; 320x240 frame of 0xFFFF -> exactly 19200 writes, addr 0..19199 ascending, data 0xFF, frame_done once, frame_err=0.
REQ-038 Bench scenario 2: pixel 0xF800 at line0/col0 -> wr_data=76 with macro, 0 without; write 2 cycles after the low byte.
REQ-039 Bench scenario 3: frame with 239 lines -> frame_err=1 after frame_done; next full frame clears it to 0.
REQ-040 Bench scenario 4: enable raised mid-frame (VSYNC already 1) -> no writes until the next VSYNC rise; enable dropped mid-capture -> frame completes, then S_IDLE.
REQ-041 Bench scenario 5: 330-pixel lines with an odd trailing byte -> only col<320 written, no extra write, addresses unchanged.
REQ-042 Bench scenario 6: reset_n pulsed low at line 100 -> all outputs 0 immediately, no writes until the next VSYNC rise with enable=1.
